// File: rtl/tp_mem_banked.sv
// Two-port (1R/1W) word memory split into NBANKS equal slices, with per-bank write
// masking, 1- or 2-cycle read latency, optional read-during-write bypass and post-reset clear.
module tp_mem_banked #(
  parameter int DEPTH          = 64,
  parameter int AWIDTH         = 6,
  parameter int WIDTH          = 2048,
  parameter int NBANKS         = 2,
  parameter int RD_LAT         = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_word,
  output logic              rd_vld,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [NBANKS-1:0] wr_mask,
  input  logic [WIDTH-1:0]  wr_word,
  output logic              init_busy
);

  localparam int BW = WIDTH / NBANKS;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state_reg;
  logic [AWIDTH-1:0] clr_addr_reg;
  logic              init_busy_reg;

  logic              clearing;
  logic              rd_acc;
  logic              wr_acc;
  logic              same_addr;
  logic              vld1_reg;
  logic [WIDTH-1:0]  s1_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr_reg  <= '0;
      state_reg     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      init_busy_reg <= (CLEAR_ON_RESET != 0);
    end else if (state_reg == CLEAR) begin
      clr_addr_reg <= clr_addr_reg + 1'b1;
      if (clr_addr_reg == AWIDTH'(DEPTH - 1)) begin
        state_reg     <= READY;
        init_busy_reg <= 1'b0;
      end
    end
  end

  assign init_busy = init_busy_reg;
  assign clearing  = (state_reg == CLEAR);
  assign rd_acc    = rd_en & (state_reg == READY);
  assign wr_acc    = wr_en & (state_reg == READY);
  assign same_addr = (rd_addr == wr_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_reg <= 1'b0;
    end else begin
      vld1_reg <= rd_acc;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_bank
      logic [BW-1:0]     mem [DEPTH];
      logic [BW-1:0]     q_reg;
      logic [BW-1:0]     byp_data_reg;
      logic              byp_reg;
      logic              we;
      logic [AWIDTH-1:0] wa;
      logic [BW-1:0]     wd;

      // The clear sequencer owns the write port while it runs.
      assign we = clearing | (wr_acc & wr_mask[gi]);
      assign wa = clearing ? clr_addr_reg : wr_addr;
      assign wd = clearing ? '0 : wr_word[gi*BW +: BW];

      always_ff @(posedge clk) begin
        if (we) begin
          mem[wa] <= wd;
        end
      end

      // Array read returns pre-write data; the bypass flag selects the captured write slice.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg        <= '0;
          byp_data_reg <= '0;
          byp_reg      <= 1'b0;
        end else if (rd_acc) begin
          q_reg        <= mem[rd_addr];
          byp_data_reg <= wr_word[gi*BW +: BW];
          byp_reg      <= (BYPASS != 0) && wr_acc && wr_mask[gi] && same_addr;
        end
      end

      assign s1_word[gi*BW +: BW] = byp_reg ? byp_data_reg : q_reg;
    end

    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] word2_reg;
      logic             vld2_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          word2_reg <= '0;
          vld2_reg  <= 1'b0;
        end else begin
          vld2_reg <= vld1_reg;
          if (vld1_reg) begin
            word2_reg <= s1_word;
          end
        end
      end

      assign rd_word = word2_reg;
      assign rd_vld  = vld2_reg;
    end else begin : g_lat1
      assign rd_word = s1_word;
      assign rd_vld  = vld1_reg;
    end
  endgenerate

endmodule
